// File: rtl/xpar_arb_pkg.sv
// xpar_arb_pkg: shared state encoding and sizing helpers for the parallel-interface arbiter
package xpar_arb_pkg;
  typedef enum logic [1:0] {
    XPAR_IDLE   = 2'd0,
    XPAR_ACCESS = 2'd1,
    XPAR_ACK    = 2'd2
  } xpar_state_t;
  localparam int XPAR_ADDR_W = 13;
  localparam int XPAR_PADDR_W = XPAR_ADDR_W - 1;
  function automatic int idx_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/xpar_arb_xrr_pick.sv
// xrr_pick: combinational round-robin selector, first request at or after ptr wins
module xrr_pick
  import xpar_arb_pkg::*;
#(
  parameter int N = 2,
  localparam int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          valid
);
  // Walk the requesters starting at ptr with wrap-around, stopping at the first one asserted
  always_comb begin
    logic [IW-1:0] j;
    gnt = '0;
    idx = '0;
    valid = 1'b0;
    j = '0;
    for (int k = 0; k < N; k++) begin
      j = IW'((int'(ptr) + k) % N);
      if (!valid && req[j]) begin
        valid = 1'b1;
        idx = j;
        gnt[j] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/xpar_arb.sv
// xpar_arb: round-robin arbiter and wait-state sequencer for the external parallel interface
module xpar_arb
  import xpar_arb_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int DATA_W = 32,
  parameter int PADDR_W = XPAR_PADDR_W,
  parameter int WAIT_CYC = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ-1:0]         req_we,
  input  logic [N_REQ*PADDR_W-1:0] req_addr,
  input  logic [N_REQ*DATA_W-1:0]  req_wdata,
  output logic [N_REQ-1:0]         ack,
  output logic [DATA_W-1:0]        rdata,
  output logic [N_REQ-1:0]         grant,
  output logic                     busy,
  output logic [PADDR_W-1:0]       par_addr,
  input  logic [DATA_W-1:0]        par_in,
  output logic                     par_re,
  output logic [DATA_W-1:0]        par_out,
  output logic                     par_we
);
  localparam int IW = idx_w(N_REQ);
  xpar_state_t   state;
  logic [IW-1:0] ptr, g_idx, pick_idx;
  logic [N_REQ-1:0] pick_gnt;
  logic          pick_valid;
  logic [3:0]    cnt;
  xrr_pick #(.N(N_REQ)) u_pick (
    .req   (req),
    .ptr   (ptr),
    .gnt   (pick_gnt),
    .idx   (pick_idx),
    .valid (pick_valid)
  );
  // One access at a time: latch the winner, hold the strobe WAIT_CYC+1 cycles, then pulse ack
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= XPAR_IDLE;
      ptr <= '0;
      g_idx <= '0;
      cnt <= '0;
      ack <= '0;
      rdata <= '0;
      grant <= '0;
      busy <= 1'b0;
      par_addr <= '0;
      par_re <= 1'b0;
      par_out <= '0;
      par_we <= 1'b0;
    end else begin
      case (state)
        XPAR_IDLE: if (pick_valid) begin
          state <= XPAR_ACCESS;
          grant <= pick_gnt;
          g_idx <= pick_idx;
          busy <= 1'b1;
          cnt <= 4'(WAIT_CYC);
          par_addr <= req_addr[int'(pick_idx)*PADDR_W +: PADDR_W];
          par_out <= req_wdata[int'(pick_idx)*DATA_W +: DATA_W];
          par_we <= req_we[pick_idx];
          par_re <= ~req_we[pick_idx];
        end
        XPAR_ACCESS: if (cnt == 4'd0) begin
          state <= XPAR_ACK;
          par_re <= 1'b0;
          par_we <= 1'b0;
          ack <= grant;
          if (par_re) rdata <= par_in;
        end else begin
          cnt <= cnt - 4'd1;
        end
        XPAR_ACK: begin
          state <= XPAR_IDLE;
          ack <= '0;
          grant <= '0;
          busy <= 1'b0;
          ptr <= (g_idx == IW'(N_REQ - 1)) ? '0 : g_idx + 1'b1;
        end
        default: state <= XPAR_IDLE;
      endcase
    end
  end
endmodule
